rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 register file's single write port. Shares the write port between `NREQ` producers (ALU, load unit, mult/div unit) with round-robin valid/ready handshakes and drives the register-file write controls (`Rdc`, `Rd`, `RF_W`) from a registered output stage. Tracks outstanding destination-register claims from the issue stage and exports a per-register `busy` vector for hazard stalls.

## Interface
- `NREQ`, 3, number of write-back requesters (2..4)
- `DW`, 32, data width
- `AW`, 5, register address width (2^AW registers)
- `WBA_clk`  in  1  clock; all state updates on its rising edge
- `WBA_rst_n`  in  1  reset, asynchronous, active-low
- `WBA_ena`  in  1  block enable; 0 = no grants, no claims, `RF_W`=0
- `req_valid`  in  NREQ  per-requester write request
- `req_ready`  out  NREQ  per-requester grant (combinational)
- `req_addr`  in  NREQ*AW  packed destination addresses, requester i at [i*AW +: AW]
- `req_data`  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- `claim_valid`  in  1  issue stage reserves a destination register
- `claim_addr`  in  AW  register being reserved
- `claim_ready`  out  1  claim accepted this cycle (combinational)
- `Rdc`  out  AW  register-file write address (registered)
- `Rd`  out  DW  register-file write data (registered)
- `RF_W`  out  1  register-file write strobe (registered)
- `busy`  out  2^AW  bit r = register r has pending writes
- `sb_err`  out  1  sticky scoreboard underflow flag

## Operation
- Arbitration: pointer `ptr` (0..NREQ-1). When `WBA_ena`=1, the winner is the first i with `req_valid[i]`=1, searching ptr, ptr+1, … cyclically. `req_ready` is one-hot on the winner and zero otherwise; all zero if nothing is valid, `WBA_ena`=0, or reset is active.
- On handshake (`req_valid[i]` & `req_ready[i]`): `ptr` <= (i+1) mod NREQ. With no handshake, `ptr` holds.
- Output stage: on handshake, `Rdc`<=addr, `Rd`<=data, `RF_W`<=(addr!=0). With no handshake, `RF_W`<=0 and `Rdc`/`Rd` hold. A write to r0 completes its handshake but never strobes `RF_W`.
- The write port never backpressures, so at most one grant per cycle and no buffering beyond the output register.
- Scoreboard: 2-bit saturating pending counter `cnt[r]` per register.
  - Claim: `claim_ready` = `WBA_ena` & (`claim_addr`==0 | `cnt[claim_addr]`!=3).
  - Accepted claim to r!=0 increments `cnt[r]`. Claims to r0 are accepted and ignored.
  - Commit: a cycle with `RF_W`=1 decrements `cnt[Rdc]` at the same edge the register file captures the data.
  - Claim and commit to the same register in one cycle leave `cnt` unchanged. Claim and commit to different registers both apply.
  - Commit with `cnt[Rdc]`==0 leaves the counter at 0 and sets `sb_err`<=1, which is sticky until reset.
- `busy[r]` = (`cnt[r]`!=0); `busy[0]` is always 0.
- `WBA_ena`=0: no grants, no claims, `RF_W`<=0. A commit already in the output register still decrements its counter.

## Timing
- Reset (async, while `WBA_rst_n`=0):
  - `Rdc`=0, `Rd`=0, `RF_W`=0, `ptr`=0, all `cnt`=0, `busy`=0, `sb_err`=0.
  - `req_ready`=0 and `claim_ready`=0.
  - Pending claims and any in-flight write are discarded.
- Latency: handshake in cycle N → `RF_W`/`Rdc`/`Rd` valid in cycle N+1 → register file written and `cnt` decremented at the end of cycle N+1. `busy` drops in cycle N+2.
- Throughput: one write per cycle, sustained.
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles.
- Claim to `busy` visibility: claim accepted in cycle N → `busy[r]`=1 from cycle N+1.

## Test plan
- Reset: hold `WBA_rst_n`=0 while driving requests and claims → all outputs 0, `req_ready`=0, `claim_ready`=0. Release → first grant goes to requester 0 if it is valid.
- Round-robin: NREQ=3, all `req_valid`=1 for 6 cycles with addr 1/2/3 → grants 0,1,2,0,1,2. `Rdc` one cycle later: 1,2,3,1,2,3. `RF_W`=1 in each of those cycles.
- Scoreboard: claim r5 twice, then requester 1 writes r5 twice → `busy[5]` goes 0→1 and returns to 0 only after the second `RF_W` cycle (cnt 2→1→0).
- r0 write: requester 2 writes addr 0, data 0xDEADBEEF → `req_ready[2]`=1, next-cycle `RF_W`=0, `busy` unchanged, `sb_err`=0.
- Boundaries:
  - Claim r7 three times → cnt 3; a fourth claim sees `claim_ready`=0.
  - Claim r7 in the same cycle as a commit to r7 → cnt stays at its value.
  - Commit to r9 with cnt 0 → `sb_err`=1, and it stays 1 afterwards.
- Mid-operation: assert `WBA_rst_n`=0 during a continuous burst with `busy[4]`=1 → `RF_W`, `busy`, and `ptr` clear immediately. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the producers/issue stage and the register-file arbiter.
// master = producers and issue stage; slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               claim_valid;
  logic [AW-1:0]      claim_addr;
  logic               claim_ready;
  logic [AW-1:0]      Rdc;
  logic [DW-1:0]      Rd;
  logic               RF_W;
  logic [(1<<AW)-1:0] busy;
  logic               sb_err;

  modport master (
    output req_valid, req_addr, req_data, claim_valid, claim_addr,
    input  req_ready, claim_ready, Rdc, Rd, RF_W, busy, sb_err
  );
  modport slave (
    input  req_valid, req_addr, req_data, claim_valid, claim_addr,
    output req_ready, claim_ready, Rdc, Rd, RF_W, busy, sb_err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the single RF write port, plus a
// per-register 2-bit pending-write scoreboard driving the busy vector.

module rf_wb_sb_cnt (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic uflow
);
  logic [1:0] cnt;

  assign busy  = (cnt != 2'd0);
  assign full  = (cnt == 2'd3);
  // A simultaneous claim and commit cancel out, so only a lone commit can underflow.
  assign uflow = dec & ~inc & (cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt <= 2'd0;
    else if (inc & ~dec & (cnt != 2'd3))  cnt <= cnt + 2'd1;
    else if (dec & ~inc & (cnt != 2'd0))  cnt <= cnt - 2'd1;
  end
endmodule

module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic             WBA_clk,
  input  logic             WBA_rst_n,
  input  logic             WBA_ena,
  rf_wb_arbiter_if.slave   bus
);
  localparam int NR = 1 << AW;
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr, win;
  logic [NREQ-1:0] gnt;
  logic            hs;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            rf_w_q;
  logic [AW-1:0]   rdc_q;
  logic [DW-1:0]   rd_q;
  logic            sb_err_q;
  logic            claim_ok;
  logic [NR-1:0]   inc, dec, busy_r, full, uflow;

  // Cyclic first-valid search starting at ptr; a grant is always a handshake.
  always_comb begin
    int idx;
    gnt = '0;
    win = '0;
    hs  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hs && bus.req_valid[idx]) begin
        hs       = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx[PW-1:0];
      end
    end
    if (!WBA_ena || !WBA_rst_n) begin
      gnt = '0;
      hs  = 1'b0;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_data = bus.req_data[i*DW +: DW];
      end
  end

  always_ff @(posedge WBA_clk or negedge WBA_rst_n) begin
    if (!WBA_rst_n) begin
      ptr    <= '0;
      rf_w_q <= 1'b0;
      rdc_q  <= '0;
      rd_q   <= '0;
    end else if (hs) begin
      ptr    <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
      rf_w_q <= (sel_addr != '0);
      rdc_q  <= sel_addr;
      rd_q   <= sel_data;
    end else begin
      rf_w_q <= 1'b0;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.Rdc         = rdc_q;
  assign bus.Rd          = rd_q;
  assign bus.RF_W        = rf_w_q;
  assign bus.claim_ready = WBA_ena & WBA_rst_n &
                           ((bus.claim_addr == '0) | ~full[bus.claim_addr]);
  assign claim_ok        = bus.claim_valid & bus.claim_ready;

  // r0 is never claimed nor committed, so its counter stays at zero.
  for (genvar r = 0; r < NR; r++) begin : g_sb
    assign inc[r] = claim_ok && (r != 0) && (bus.claim_addr == AW'(r));
    assign dec[r] = rf_w_q && (rdc_q == AW'(r));
    rf_wb_sb_cnt u_cnt (
      .clk   (WBA_clk),
      .rst_n (WBA_rst_n),
      .inc   (inc[r]),
      .dec   (dec[r]),
      .busy  (busy_r[r]),
      .full  (full[r]),
      .uflow (uflow[r])
    );
  end

  always_ff @(posedge WBA_clk or negedge WBA_rst_n) begin
    if (!WBA_rst_n) sb_err_q <= 1'b0;
    else if (|uflow) sb_err_q <= 1'b1;
  end

  assign bus.busy   = busy_r;
  assign bus.sb_err = sb_err_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: table-driven round-robin vectors, hand-written
// scoreboard/reset sequences, and a randomized run against a queue/array model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic WBA_clk = 1'b0;
  logic WBA_rst_n;
  logic WBA_ena;
  int   n_chk = 0;
  int   n_fail = 0;

  rf_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .WBA_clk   (WBA_clk),
    .WBA_rst_n (WBA_rst_n),
    .WBA_ena   (WBA_ena),
    .bus       (bus)
  );

  always #5 WBA_clk = ~WBA_clk;

  typedef struct {
    logic       ena;
    logic [2:0] vld;
    logic [2:0] gnt;
    logic       rfw;
    logic [4:0] rdc;
  } vec_t;
  vec_t tbl[14];

  // reference model state
  int          m_ptr;
  int          m_cnt[32];
  logic        m_rfw;
  logic [4:0]  m_rdc;
  logic [31:0] m_rd;
  logic        m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge WBA_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic idle_inputs();
    WBA_ena         = 1'b1;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.claim_valid = 1'b0;
    bus.claim_addr  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    WBA_rst_n = 1'b0;
    tick();
    tick();
    WBA_rst_n = 1'b1;
  endtask

  task automatic claim(input logic [4:0] a);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = a;
  endtask

  initial begin
    logic [2:0]  vld, egnt;
    logic [4:0]  ad [3];
    logic [31:0] dt [3];
    logic        cv, ecr, acc, found;
    logic [4:0]  ca;
    logic [31:0] ebusy;
    int          w;
    int          pend[$];

    tbl[0]  = '{1'b1, 3'b111, 3'b001, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 3'b111, 3'b010, 1'b1, 5'd1};
    tbl[2]  = '{1'b1, 3'b111, 3'b100, 1'b1, 5'd2};
    tbl[3]  = '{1'b1, 3'b111, 3'b001, 1'b1, 5'd3};
    tbl[4]  = '{1'b1, 3'b111, 3'b010, 1'b1, 5'd1};
    tbl[5]  = '{1'b1, 3'b111, 3'b100, 1'b1, 5'd2};
    tbl[6]  = '{1'b1, 3'b000, 3'b000, 1'b1, 5'd3};
    tbl[7]  = '{1'b1, 3'b110, 3'b010, 1'b0, 5'd3};
    tbl[8]  = '{1'b1, 3'b101, 3'b100, 1'b1, 5'd2};
    tbl[9]  = '{1'b1, 3'b101, 3'b001, 1'b1, 5'd3};
    tbl[10] = '{1'b1, 3'b100, 3'b100, 1'b1, 5'd1};
    tbl[11] = '{1'b1, 3'b011, 3'b001, 1'b1, 5'd3};
    tbl[12] = '{1'b0, 3'b111, 3'b000, 1'b1, 5'd1};
    tbl[13] = '{1'b1, 3'b111, 3'b010, 1'b0, 5'd1};

    // Reset held while requests and claims are driven
    idle_inputs();
    WBA_rst_n = 1'b0;
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1111_1111);
    claim(5'd3);
    #2;
    @(negedge WBA_clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_claim_ready", bus.claim_ready, 0);
    chk("rst_rfw", bus.RF_W, 0);
    chk("rst_rdc", bus.Rdc, 0);
    chk("rst_rd", bus.Rd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sb_err", bus.sb_err, 0);
    tick();
    WBA_rst_n = 1'b1;
    @(negedge WBA_clk);
    chk("rst_first_gnt", bus.req_ready, 3'b001);

    // Round-robin table
    do_reset();
    set_req(0, 5'd1, 32'h1111_1111);
    set_req(1, 5'd2, 32'h2222_2222);
    set_req(2, 5'd3, 32'h3333_3333);
    for (int t = 0; t < 14; t++) begin
      WBA_ena       = tbl[t].ena;
      bus.req_valid = tbl[t].vld;
      @(negedge WBA_clk);
      chk($sformatf("rr%0d_gnt", t), bus.req_ready, tbl[t].gnt);
      chk($sformatf("rr%0d_rfw", t), bus.RF_W, tbl[t].rfw);
      chk($sformatf("rr%0d_rdc", t), bus.Rdc, tbl[t].rdc);
      tick();
    end

    // Scoreboard r5: two claims, two commits
    do_reset();
    claim(5'd5);
    @(negedge WBA_clk);
    chk("sb5_claim_ready", bus.claim_ready, 1);
    chk("sb5_busy_pre", bus.busy[5], 0);
    tick();
    @(negedge WBA_clk);
    chk("sb5_busy_c1", bus.busy[5], 1);
    tick();
    bus.claim_valid = 1'b0;
    bus.req_valid   = 3'b010;
    set_req(1, 5'd5, 32'hA5A5_0001);
    @(negedge WBA_clk);
    chk("sb5_gnt1", bus.req_ready, 3'b010);
    tick();
    set_req(1, 5'd5, 32'hA5A5_0002);
    @(negedge WBA_clk);
    chk("sb5_rfw1", bus.RF_W, 1);
    chk("sb5_rdc1", bus.Rdc, 5);
    chk("sb5_busy_w1", bus.busy[5], 1);
    tick();
    bus.req_valid = '0;
    @(negedge WBA_clk);
    chk("sb5_rfw2", bus.RF_W, 1);
    chk("sb5_rd2", bus.Rd, 32'hA5A5_0002);
    chk("sb5_busy_w2", bus.busy[5], 1);
    tick();
    @(negedge WBA_clk);
    chk("sb5_busy_done", bus.busy[5], 0);
    chk("sb5_rfw_off", bus.RF_W, 0);
    chk("sb5_sb_err", bus.sb_err, 0);
    tick();

    // Write to r0
    bus.req_valid = 3'b100;
    set_req(2, 5'd0, 32'hDEAD_BEEF);
    @(negedge WBA_clk);
    chk("r0_gnt", bus.req_ready, 3'b100);
    tick();
    bus.req_valid = '0;
    @(negedge WBA_clk);
    chk("r0_rfw", bus.RF_W, 0);
    chk("r0_rd", bus.Rd, 32'hDEAD_BEEF);
    chk("r0_busy", bus.busy, 0);
    chk("r0_sb_err", bus.sb_err, 0);
    tick();

    // r7 saturation, then claim+commit in the same cycle
    claim(5'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge WBA_clk);
      chk($sformatf("r7_claim%0d", i), bus.claim_ready, 1);
      tick();
    end
    @(negedge WBA_clk);
    chk("r7_full", bus.claim_ready, 0);
    tick();
    bus.claim_valid = 1'b0;
    bus.req_valid   = 3'b001;
    set_req(0, 5'd7, 32'h7777_0001);
    tick();
    @(negedge WBA_clk);
    chk("r7_commit1", bus.RF_W, 1);
    tick();
    bus.req_valid = '0;
    claim(5'd7);
    @(negedge WBA_clk);
    chk("r7_commit2_rdc", bus.Rdc, 7);
    chk("r7_same_claim_ready", bus.claim_ready, 1);
    tick();
    @(negedge WBA_clk);
    chk("r7_after_same", bus.claim_ready, 1);
    tick();
    @(negedge WBA_clk);
    chk("r7_full_again", bus.claim_ready, 0);
    tick();
    bus.claim_valid = 1'b0;

    // Commit to r9 with no pending claim
    bus.req_valid = 3'b001;
    set_req(0, 5'd9, 32'h9999_9999);
    tick();
    bus.req_valid = '0;
    @(negedge WBA_clk);
    chk("r9_rfw", bus.RF_W, 1);
    chk("r9_err_pre", bus.sb_err, 0);
    tick();
    @(negedge WBA_clk);
    chk("r9_err_set", bus.sb_err, 1);
    tick();
    tick();
    tick();
    @(negedge WBA_clk);
    chk("r9_err_sticky", bus.sb_err, 1);

    // Reset in the middle of a burst
    do_reset();
    claim(5'd4);
    tick();
    bus.claim_valid = 1'b0;
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd2, 32'h2);
    set_req(2, 5'd3, 32'h3);
    tick();
    tick();
    chk("mid_rfw_pre", bus.RF_W, 1);
    chk("mid_busy4_pre", bus.busy[4], 1);
    #1;
    WBA_rst_n = 1'b0;
    #1;
    chk("mid_rfw_rst", bus.RF_W, 0);
    chk("mid_busy_rst", bus.busy, 0);
    chk("mid_ready_rst", bus.req_ready, 0);
    tick();
    WBA_rst_n = 1'b1;
    @(negedge WBA_clk);
    chk("mid_restart_gnt", bus.req_ready, 3'b001);

    // Randomized run against the reference model
    do_reset();
    m_ptr = 0; m_rfw = 1'b0; m_rdc = '0; m_rd = '0; m_err = 1'b0;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    for (int c = 0; c < 2000; c++) begin
      pend.delete();
      for (int r = 1; r < 8; r++) if (m_cnt[r] != 0) pend.push_back(r);
      WBA_ena = ($urandom_range(0, 9) != 0);
      vld = 3'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        if (pend.size() != 0 && $urandom_range(0, 3) != 0)
          ad[i] = 5'(pend[$urandom_range(0, pend.size() - 1)]);
        else
          ad[i] = 5'($urandom_range(0, 7));
        dt[i] = $urandom;
        set_req(i, ad[i], dt[i]);
      end
      cv = 1'($urandom_range(0, 1));
      ca = 5'($urandom_range(0, 7));
      if (m_rfw && ca == m_rdc && m_cnt[ca] == 0) cv = 1'b0;
      bus.req_valid   = vld;
      bus.claim_valid = cv;
      bus.claim_addr  = ca;

      egnt = '0; found = 1'b0; w = 0;
      if (WBA_ena)
        for (int k = 0; k < NREQ; k++)
          if (!found && vld[(m_ptr + k) % NREQ]) begin
            found = 1'b1;
            w = (m_ptr + k) % NREQ;
            egnt[w] = 1'b1;
          end
      ecr = WBA_ena && (ca == 0 || m_cnt[ca] != 3);
      ebusy = '0;
      for (int r = 1; r < 32; r++) ebusy[r] = (m_cnt[r] != 0);

      @(negedge WBA_clk);
      chk("rnd_gnt", bus.req_ready, egnt);
      chk("rnd_claim_ready", bus.claim_ready, ecr);
      chk("rnd_rfw", bus.RF_W, m_rfw);
      chk("rnd_rdc", bus.Rdc, m_rdc);
      chk("rnd_rd", bus.Rd, m_rd);
      chk("rnd_busy", bus.busy, ebusy);
      chk("rnd_sb_err", bus.sb_err, m_err);

      acc = cv && ecr;
      if (m_rfw && !(acc && ca == m_rdc)) begin
        if (m_cnt[m_rdc] == 0) m_err = 1'b1;
        else m_cnt[m_rdc]--;
      end
      if (acc && ca != 0 && !(m_rfw && ca == m_rdc)) m_cnt[ca]++;
      m_rfw = 1'b0;
      if (found) begin
        m_rdc = ad[w];
        m_rd  = dt[w];
        m_rfw = (ad[w] != 0);
        m_ptr = (w + 1) % NREQ;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
